lfsr_share_ctrl: RTL
====================

// Module: lfsr_share_ctrl
// PURPOSE
//   Owns one Fibonacci LFSR and shares it between two requesters.
//   Round-robin arbitration between the requesters.
//   Advances the LFSR STEPS shifts per grant, so consecutive words are decorrelated.
//   Returns the resulting word with a one-cycle ack.
//   Also handles seeding, and forces any all-zero seed to 1.
//   Sits between the pseudo-random consumers (test-pattern, scrambler) and the shared LFSR.
// PARAMETERS
//   N      8     LFSR length in stages, 3..32
//   TAPS   8'hB8 feedback mask [N-1:0]; bit k-1 set => stage k XORed into feedback
//                (default = stages 8,6,5,4, maximal length)
//   STEPS  8     shifts per grant, 1..2^16-1
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   seed_valid in   1   load seed_data into the LFSR (accepted in IDLE only)
//   seed_data  in   N   seed; stage k = seed_data[N-k]
//   req        in   2   req[i]: requester i wants a word; held high until ack[i]
//   ack        out  2   one-cycle pulse; ack[i] => rnd_data valid for requester i
//   rnd_data   out  N   LFSR word; stage k on rnd_data[N-k]; valid while ack != 0
//   busy       out  1   high in STEP and ACK
// BEHAVIOUR
//   Clock and reset
//   - Single clock: clk. Reset is asynchronous and active-high, on port reset.
//   Reset state
//   - LFSR = 1 (stage N = 1, others 0), FSM = IDLE, step counter = 0.
//   - ack = 0, rnd_data = 0, busy = 0.
//   - rr_last = 1, so req[0] wins the first tie.
//   - Reset mid-operation aborts the grant; no ack is issued.
//   LFSR shift (in STEP only)
//   - fb = XOR of stages k with TAPS[k-1] = 1.
//   - stage1 <= fb; stage k <= stage k-1 for k = 2..N.
//   - The LFSR holds its value in every other state.
//   States
//   - IDLE:
//     - seed_valid has priority over req in the same cycle.
//     - Load: LFSR <= seed_data, or 1 if seed_data == 0. Stay in IDLE.
//     - Otherwise, if req != 0: grant g, cnt <= STEPS-1, go to STEP.
//     - g = the only requester if one is asking. If both ask, g = !rr_last.
//   - STEP:
//     - Shift once per cycle.
//     - If cnt == 0, go to ACK; else cnt <= cnt-1.
//     - Exactly STEPS shifts are performed.
//   - ACK:
//     - Registered outputs: ack[g] = 1 and rnd_data = LFSR for one cycle.
//     - rr_last <= g. Go to IDLE.
//     - In every non-ACK cycle ack = 0 and rnd_data = 0.
//   Timing
//   - Latency: req sampled at edge t => ack high in cycle t+STEPS+1.
//   - Throughput: one word per STEPS+2 cycles.
//   Boundary conditions
//   - seed_valid in STEP/ACK: ignored (not queued). Upstream retries after busy falls.
//   - req[g] dropped before ack: the grant still completes and ack[g] still pulses.
//   - A requester sees ack at most once per grant.
//   - A req held high after its ack is a new request in the following IDLE cycle.
//   - With both requesters asking continuously, grants alternate 0,1,0,1...
//   - The LFSR never holds 0; a zero seed yields 1.
// TESTING  (N=8, TAPS=8'hB8, STEPS=8)
//   1. Reset, then req=2'b01 held:
//      ack=2'b01 exactly 9 cycles after the sampling edge;
//      rnd_data = 8'h71 (shifts 1 to 8 from 8'h01: 80,40,20,10,88,C4,E2,71).
//   2. req=2'b11 held for 4 grants:
//      ack order 01,10,01,10; each ack is one cycle wide, 10 cycles apart.
//   3. seed_valid=1 with seed_data=0 in IDLE, then req=2'b10:
//      same word as scenario 1 (8'h71) on ack=2'b10.
//   4. seed_valid=1, seed_data=8'hFF together with req=2'b01:
//      the seed loads that cycle and the request is granted the next cycle;
//      after 8 shifts, the bench reference model matches rnd_data.
//   5. Assert reset during STEP (cycle 4 of 8):
//      ack never pulses; after release, busy=0 and LFSR=8'h01.
//   6. Free-run 255 grants of 1 step each (STEPS=1 build):
//      all 255 nonzero values appear once, and 8'h00 never appears.

Source files
------------

// File: rtl/lfsr_share_if.sv
// lfsr_share_if: request/ack and seeding bus between LFSR consumers and the shared LFSR controller
interface lfsr_share_if #(parameter int N = 8);
  logic         seed_valid;
  logic [N-1:0] seed_data;
  logic [1:0]   req;
  logic [1:0]   ack;
  logic [N-1:0] rnd_data;
  logic         busy;
  modport master (output seed_valid, seed_data, req, input ack, rnd_data, busy);
  modport slave  (input seed_valid, seed_data, req, output ack, rnd_data, busy);
endinterface

// File: rtl/lfsr_share_ctrl.sv
// lfsr_share_ctrl: round-robin shares one Fibonacci LFSR between two requesters, STEPS shifts per grant
module lfsr_share_ctrl #(
  parameter int           N     = 8,
  parameter logic [N-1:0] TAPS  = N'(8'hB8),
  parameter int           STEPS = 8
) (
  input  logic       clk,
  input  logic       reset,
  lfsr_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STEP, ACK} state_t;
  localparam logic [15:0] CNT_INIT = 16'(STEPS - 1);
  state_t       state_q;
  logic [N-1:0] lfsr_q, lfsr_d, rnd_q;
  logic [15:0]  cnt_q;
  logic [1:0]   ack_q;
  logic         g_q, rr_last_q, busy_q, g_sel, fb;
  // stage k lives on bit N-k, so a shift moves the word towards bit 0
  always_comb begin
    fb = 1'b0;
    for (int k = 1; k <= N; k++) if (TAPS[k-1]) fb = fb ^ lfsr_q[N-k];
    lfsr_d = {fb, lfsr_q[N-1:1]};
  end
  assign g_sel = (bus.req == 2'b11) ? ~rr_last_q : bus.req[1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= N'(1);
      cnt_q     <= '0;
      g_q       <= 1'b0;
      rr_last_q <= 1'b1;
      ack_q     <= '0;
      rnd_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      rnd_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.seed_valid) begin
            lfsr_q <= (bus.seed_data == '0) ? N'(1) : bus.seed_data;
          end else if (|bus.req) begin
            g_q     <= g_sel;
            cnt_q   <= CNT_INIT;
            state_q <= STEP;
            busy_q  <= 1'b1;
          end
        end
        STEP: begin
          lfsr_q <= lfsr_d;
          if (cnt_q == '0) begin
            state_q <= ACK;
            ack_q   <= g_q ? 2'b10 : 2'b01;
            rnd_q   <= lfsr_d;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ACK: begin
          rr_last_q <= g_q;
          state_q   <= IDLE;
          busy_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ack      = ack_q;
  assign bus.rnd_data = rnd_q;
  assign bus.busy     = busy_q;
endmodule
